datamemory_bytelane: RTL and testbench

Parametrised byte-lane data memory for the RISC-V pipeline MEM stage, successor to the 32-bit word-only data memory. Supports SB/SH/SW(/SD) stores via byte enables, and LB/LH/LW/LBU/LHU(/LD/LWU) loads with sign/zero extension. Loads have a registered one-cycle read. Misaligned or illegal accesses are flagged, and the array is zero-cleared by a post-reset sweep.

---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/datamemory_bytelane_if.sv | 27 ++
 rtl/dmem_bank.sv | 33 +++
 rtl/datamemory_bytelane.sv | 155 +++++++++++++++
 tb/tb_datamemory_bytelane.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
//   funct3_e : load encodings (LB..LWU); store encodings alias the same values
//   state_e  : INIT (zero sweep) / RUN (accepting requests)
//   be_gen   : byte-enable mask (up to 8 lanes) for an access size at an offset
//   is_aligned, legal_load, legal_store : fault classification helpers
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } funct3_e;

    // Stores share the load size encoding; an enum cannot hold duplicate
    // values, so the store names are aliases.
    localparam funct3_e SB = LB;
    localparam funct3_e SH = LH;
    localparam funct3_e SW = LW;
    localparam funct3_e SD = LD;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [7:0] be_gen(input logic [2:0] funct3, input logic [2:0] offset);
        case (funct3)
            LB, LBU: be_gen = 8'h01 << offset;
            LH, LHU: be_gen = 8'h03 << offset;
            LW, LWU: be_gen = 8'h0F << offset;
            default: be_gen = 8'hFF;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] offset);
        case (funct3)
            LB, LBU: is_aligned = 1'b1;
            LH, LHU: is_aligned = (offset[0] == 1'b0);
            LW, LWU: is_aligned = (offset[1:0] == 2'b00);
            LD:      is_aligned = (offset == 3'b000);
            default: is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic legal_load(input logic [2:0] funct3, input logic is64);
        case (funct3)
            LB, LH, LW, LBU, LHU: legal_load = 1'b1;
            LD, LWU:              legal_load = is64;
            default:              legal_load = 1'b0;
        endcase
    endfunction

    function automatic logic legal_store(input logic [2:0] funct3, input logic is64);
        case (funct3)
            SB, SH, SW: legal_store = 1'b1;
            SD:         legal_store = is64;
            default:    legal_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/datamemory_bytelane_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
//   MemRead/MemWrite/a/wd/Funct3 : request from the pipeline
//   ready/rd/rd_valid/fault      : status and load data from the memory
interface datamemory_bytelane_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic                  ready;
    logic [DATA_W-1:0]     rd;
    logic                  rd_valid;
    logic                  fault;

    modport master (
        output MemRead, MemWrite, a, wd, Funct3,
        input  ready, rd, rd_valid, fault
    );

    modport slave (
        input  MemRead, MemWrite, a, wd, Funct3,
        output ready, rd, rd_valid, fault
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-enabled single-clock RAM, synchronous write, registered read.
//   clk   : clock
//   we/be : write strobe and per-lane byte enables
//   waddr/wdata : write word index and lane-aligned data
//   re/raddr    : read strobe and word index; rdata updates only when re
//   rdata : registered read word (old data on same-edge read/write collision)
module dmem_bank #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/datamemory_bytelane.sv
// Byte-lane data memory for the MEM stage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of datamemory_bytelane_if (request in, load data /
//              ready / rd_valid / fault out)
// After reset the array is swept to zero one word per cycle (INIT), then
// requests are accepted one per cycle (RUN). Load results appear the cycle
// after acceptance; rd holds until the next load completes.
//
// state | meaning
// INIT  | writing zero to word[counter], ready low
// RUN   | accepting loads/stores
module datamemory_bytelane
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic clk,
    input logic rst,
    datamemory_bytelane_if.slave bus
);
    localparam int   NB    = DATA_W / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam int   IDX_W = DM_ADDRESS - OFF_W;
    localparam int   DEPTH = 2 ** IDX_W;
    localparam logic IS64  = (DATA_W == 64);

    state_e            state;
    logic [IDX_W-1:0]  counter;
    logic              ready_q;
    logic              rd_valid_q;
    logic              fault_q;
    logic              ld_ok_q;
    logic [OFF_W-1:0]  off_q;
    funct3_e           f3_q;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic              req;
    logic              both;
    logic              aligned;
    logic              bad;
    logic              ld_go;
    logic              st_go;

    logic              bank_we;
    logic [NB-1:0]     bank_be;
    logic [IDX_W-1:0]  bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;

    assign off = bus.a[OFF_W-1:0];
    assign idx = bus.a[DM_ADDRESS-1:OFF_W];

    always_comb begin
        req     = ready_q && (bus.MemRead || bus.MemWrite);
        both    = bus.MemRead && bus.MemWrite;
        aligned = is_aligned(bus.Funct3, 3'(off));
        if (both)             bad = 1'b1;
        else if (bus.MemRead) bad = !(legal_load(bus.Funct3, IS64) && aligned);
        else                  bad = !(legal_store(bus.Funct3, IS64) && aligned);
        ld_go = req && bus.MemRead && !bad;
        st_go = req && bus.MemWrite && !bad;
    end

    // The zero sweep shares the single write port with stores; stores cannot
    // collide with it because ready is low during INIT.
    always_comb begin
        if (state == INIT) begin
            bank_we    = 1'b1;
            bank_be    = '1;
            bank_waddr = counter;
            bank_wdata = '0;
        end else begin
            bank_we    = st_go;
            bank_be    = NB'(be_gen(bus.Funct3, 3'(off)));
            bank_waddr = idx;
            bank_wdata = bus.wd << {off, 3'b000};
        end
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk    (clk),
        .we     (bank_we),
        .be     (bank_be),
        .waddr  (bank_waddr),
        .wdata  (bank_wdata),
        .re     (ld_go),
        .raddr  (idx),
        .rdata  (bank_rdata)
    );

    // Extract from the registered word using the offset/Funct3 captured with
    // the load; a faulted (or no) load forces rd to zero via ld_ok_q.
    always_comb begin
        shifted = bank_rdata >> {off_q, 3'b000};
        ext     = '0;
        case (f3_q)
            LB:      ext = DATA_W'($signed(shifted[7:0]));
            LH:      ext = DATA_W'($signed(shifted[15:0]));
            LW:      ext = DATA_W'($signed(shifted[31:0]));
            LD:      ext = shifted;
            LBU:     ext = DATA_W'(shifted[7:0]);
            LHU:     ext = DATA_W'(shifted[15:0]);
            LWU:     ext = DATA_W'(shifted[31:0]);
            default: ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            counter    <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            ld_ok_q    <= 1'b0;
            off_q      <= '0;
            f3_q       <= LB;
        end else begin
            case (state)
                INIT: begin
                    rd_valid_q <= 1'b0;
                    fault_q    <= 1'b0;
                    counter    <= counter + 1'b1;
                    if (counter == IDX_W'(DEPTH - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    rd_valid_q <= req && bus.MemRead && !both;
                    fault_q    <= req && bad;
                    if (req && bus.MemRead && !both) begin
                        ld_ok_q <= !bad;
                        off_q   <= off;
                        f3_q    <= funct3_e'(bus.Funct3);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.fault    = fault_q;
    assign bus.rd       = ld_ok_q ? ext : '0;

endmodule

// File: tb/tb_datamemory_bytelane.sv
module tb_datamemory_bytelane;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    datamemory_bytelane_if #(.DM_ADDRESS(9), .DATA_W(32)) bus32 ();
    datamemory_bytelane_if #(.DM_ADDRESS(9), .DATA_W(64)) bus64 ();

    datamemory_bytelane #(.DM_ADDRESS(9), .DATA_W(32)) u32 (.clk(clk), .rst(rst), .bus(bus32));
    datamemory_bytelane #(.DM_ADDRESS(9), .DATA_W(64)) u64 (.clk(clk), .rst(rst), .bus(bus64));

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        exp_valid;
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic        chk_rd;
    } vec_t;

    localparam int NV = 24;
    vec_t v[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive32(input logic r, input logic w, input logic [8:0] a,
                           input logic [31:0] wd, input logic [2:0] f3);
        bus32.MemRead = r; bus32.MemWrite = w; bus32.a = a; bus32.wd = wd; bus32.Funct3 = f3;
    endtask

    task automatic drive64(input logic r, input logic w, input logic [8:0] a,
                           input logic [63:0] wd, input logic [2:0] f3);
        bus64.MemRead = r; bus64.MemWrite = w; bus64.a = a; bus64.wd = wd; bus64.Funct3 = f3;
    endtask

    // Waits (bounded) for bus32.ready; returns number of rising edges seen.
    task automatic wait_ready32(output int n);
        n = 0;
        while (!bus32.ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n32, n64, n;
        // ---- vector table (32-bit instance), one request per cycle ----
        v[0]  = '{Y, N, 9'h000, 32'h0,        3'b010, Y, N, 32'h00000000, Y}; // LW 0x000
        v[1]  = '{Y, N, 9'h1FC, 32'h0,        3'b010, Y, N, 32'h00000000, Y}; // LW 0x1FC
        v[2]  = '{N, Y, 9'h080, 32'hDEADBEEF, 3'b010, N, N, 32'h0,        N}; // SW 0x80
        v[3]  = '{Y, N, 9'h083, 32'h0,        3'b000, Y, N, 32'hFFFFFFDE, Y}; // LB 0x83
        v[4]  = '{Y, N, 9'h083, 32'h0,        3'b100, Y, N, 32'h000000DE, Y}; // LBU 0x83
        v[5]  = '{Y, N, 9'h080, 32'h0,        3'b001, Y, N, 32'hFFFFBEEF, Y}; // LH 0x80
        v[6]  = '{Y, N, 9'h082, 32'h0,        3'b101, Y, N, 32'h0000DEAD, Y}; // LHU 0x82
        v[7]  = '{N, Y, 9'h040, 32'h11223344, 3'b010, N, N, 32'h0,        N}; // SW 0x40
        v[8]  = '{N, Y, 9'h041, 32'h000000AA, 3'b000, N, N, 32'h0,        N}; // SB 0x41
        v[9]  = '{N, Y, 9'h042, 32'h00005566, 3'b001, N, N, 32'h0,        N}; // SH 0x42
        v[10] = '{Y, N, 9'h040, 32'h0,        3'b010, Y, N, 32'h5566AA44, Y}; // LW 0x40
        v[11] = '{Y, N, 9'h042, 32'h0,        3'b010, Y, Y, 32'h00000000, Y}; // LW misaligned
        v[12] = '{N, Y, 9'h043, 32'h0000FFFF, 3'b001, N, Y, 32'h0,        N}; // SH misaligned
        v[13] = '{Y, N, 9'h040, 32'h0,        3'b010, Y, N, 32'h5566AA44, Y}; // word unchanged
        v[14] = '{Y, Y, 9'h040, 32'h0,        3'b010, N, Y, 32'h0,        N}; // both high
        v[15] = '{Y, N, 9'h040, 32'h0,        3'b011, Y, Y, 32'h00000000, Y}; // LD on 32-bit
        v[16] = '{N, Y, 9'h1FF, 32'h00000080, 3'b000, N, N, 32'h0,        N}; // SB top byte
        v[17] = '{Y, N, 9'h1FF, 32'h0,        3'b000, Y, N, 32'hFFFFFF80, Y}; // LB top byte
        v[18] = '{N, Y, 9'h1FC, 32'h12345678, 3'b100, N, Y, 32'h0,        N}; // store f3=100
        v[19] = '{Y, N, 9'h1FC, 32'h0,        3'b010, Y, N, 32'h80000000, Y}; // not written
        v[20] = '{Y, N, 9'h1FC, 32'h0,        3'b110, Y, Y, 32'h00000000, Y}; // LWU on 32-bit
        v[21] = '{N, N, 9'h000, 32'h0,        3'b000, N, N, 32'h00000000, Y}; // idle, rd held
        v[22] = '{Y, N, 9'h1FE, 32'h0,        3'b001, Y, N, 32'hFFFF8000, Y}; // LH 0x1FE
        v[23] = '{Y, N, 9'h1FE, 32'h0,        3'b101, Y, N, 32'h00008000, Y}; // LHU 0x1FE

        drive32(N, N, 9'h0, 32'h0, 3'b000);
        drive64(N, N, 9'h0, 64'h0, 3'b000);

        // ---- reset state ----
        #2;
        check("rst ready32", bus32.ready, 0);
        check("rst rd32", bus32.rd, 0);
        check("rst rd_valid32", bus32.rd_valid, 0);
        check("rst fault32", bus32.fault, 0);
        check("rst ready64", bus64.ready, 0);
        check("rst rd64", bus64.rd, 0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- INIT length: 128 words (32-bit), 64 words (64-bit) ----
        n32 = 0; n64 = 0; n = 0;
        while ((n32 == 0 || n64 == 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n32 == 0 && bus32.ready) n32 = n;
            if (n64 == 0 && bus64.ready) n64 = n;
        end
        check("init cycles 32", n32, 128);
        check("init cycles 64", n64, 64);

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            drive32(v[i].rd_en, v[i].wr_en, v[i].a, v[i].wd, v[i].f3);
            @(posedge clk); #1;
            check($sformatf("v%0d rd_valid", i), bus32.rd_valid, v[i].exp_valid);
            check($sformatf("v%0d fault", i), bus32.fault, v[i].exp_fault);
            if (v[i].chk_rd) check($sformatf("v%0d rd", i), bus32.rd, v[i].exp_rd);
        end
        drive32(N, N, 9'h0, 32'h0, 3'b000);

        // ---- 64-bit sequence ----
        drive64(N, Y, 9'h010, 64'h8000_0001_FFFF_0000, 3'b011);           // SD 0x10
        @(posedge clk); #1;
        check("sd fault", bus64.fault, 0);
        check("sd rd_valid", bus64.rd_valid, 0);
        drive64(Y, N, 9'h014, 64'h0, 3'b110);                              // LWU 0x14
        @(posedge clk); #1;
        check("lwu rd_valid", bus64.rd_valid, 1);
        check("lwu rd", bus64.rd, 64'h0000_0000_8000_0001);
        drive64(Y, N, 9'h010, 64'h0, 3'b010);                              // LW 0x10
        @(posedge clk); #1;
        check("lw64 rd", bus64.rd, 64'hFFFF_FFFF_FFFF_0000);
        drive64(Y, N, 9'h010, 64'h0, 3'b011);                              // LD 0x10
        @(posedge clk); #1;
        check("ld rd", bus64.rd, 64'h8000_0001_FFFF_0000);
        check("ld fault", bus64.fault, 0);
        drive64(Y, N, 9'h014, 64'h0, 3'b011);                              // LD misaligned
        @(posedge clk); #1;
        check("ld misalign fault", bus64.fault, 1);
        check("ld misalign rd", bus64.rd, 0);
        drive64(N, Y, 9'h016, 64'h0000_0000_0000_1234, 3'b001);           // SH 0x16
        @(posedge clk); #1;
        check("sh64 fault", bus64.fault, 0);
        drive64(Y, N, 9'h010, 64'h0, 3'b011);
        @(posedge clk); #1;
        check("ld after sh", bus64.rd, 64'h1234_0001_FFFF_0000);
        drive64(N, N, 9'h0, 64'h0, 3'b000);

        // ---- reset during a pending load, then mid-INIT ----
        drive32(Y, N, 9'h040, 32'h0, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("rst mid-run ready", bus32.ready, 0);
        check("rst mid-run rd", bus32.rd, 0);
        @(posedge clk); #1;
        check("rst load discarded", bus32.rd_valid, 0);
        drive32(N, N, 9'h0, 32'h0, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
        end
        check("mid-init ready low", bus32.ready, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("mid-init rst rd_valid", bus32.rd_valid, 0);
        rst = 1'b0;
        wait_ready32(n);
        check("re-init cycles 32", n, 128);

        drive32(Y, N, 9'h040, 32'h0, 3'b010);
        @(posedge clk); #1;
        check("cleared 0x40 valid", bus32.rd_valid, 1);
        check("cleared 0x40 rd", bus32.rd, 0);
        drive32(Y, N, 9'h1FC, 32'h0, 3'b010);
        @(posedge clk); #1;
        check("cleared 0x1FC rd", bus32.rd, 0);
        drive32(N, N, 9'h0, 32'h0, 3'b000);
        @(posedge clk); #1;
        check("idle rd_valid", bus32.rd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
